li_expander: RTL and testbench

LI_EXPANDER -- requirements
Module: li_expander

---
 rtl/li_expander_pkg.sv | 30 +++
 rtl/li_expander_classify.sv | 32 +++
 rtl/li_expander.sv | 138 +++++++++++++
 tb/tb_li_expander.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/li_expander_pkg.sv
// li_expander_pkg: opcodes, FSM state and sequence-class types shared by the
// load-immediate expander and its classifier.
package li_expander_pkg;

  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_ADDIU = 6'h09;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEQ_ORI   = 2'd0,
    SEQ_ADDIU = 2'd1,
    SEQ_LUI   = 2'd2,
    SEQ_PAIR  = 2'd3
  } seq_t;

  // Assemble a MIPS I-type word.
  function automatic logic [31:0] itype(input logic [5:0]  op,
                                        input logic [4:0]  rs,
                                        input logic [4:0]  rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/li_expander_classify.sv
// li_classify: picks the shortest instruction sequence that rebuilds a 32-bit
// constant. FORCE_PAIR=1 always selects the LUI+ORI pair.
import li_expander_pkg::*;

module li_classify #(
  parameter int FORCE_PAIR = 0
) (
  input  logic [31:0] value,
  output seq_t        seq
);

  logic [15:0] hi;
  logic [15:0] lo;

  assign hi = value[31:16];
  assign lo = value[15:0];

  // First matching rule wins: zero-extend, sign-extend, upper-only, pair.
  always_comb begin
    seq = SEQ_PAIR;
    if (FORCE_PAIR != 0) begin
      seq = SEQ_PAIR;
    end else if (hi == 16'h0000) begin
      seq = SEQ_ORI;
    end else if (hi == 16'hFFFF && lo[15]) begin
      seq = SEQ_ADDIU;
    end else if (lo == 16'h0000) begin
      seq = SEQ_LUI;
    end
  end

endmodule

// File: rtl/li_expander.sv
// li_expander: turns a (constant, rt) request into one or two MIPS I-type
// instructions on a valid/ready output stream.
// Optional feature: define LI_EXPANDER_STATS_EN to add word/pair counters.
import li_expander_pkg::*;

module li_expander #(
  parameter int FORCE_PAIR = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_value,
  input  logic [4:0]  i_rt,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic        o_last
`ifdef LI_EXPANDER_STATS_EN
  ,
  output logic [31:0] o_word_cnt,
  output logic [31:0] o_pair_cnt
`endif
);

  state_t      state_reg, state_next;
  logic [31:0] instr_reg, instr_next;
  logic        last_reg, last_next;
  logic [31:0] second_reg, second_next;
  seq_t        seq;

  logic [15:0] hi;
  logic [15:0] lo;

  assign hi = i_value[31:16];
  assign lo = i_value[15:0];

  li_classify #(
    .FORCE_PAIR(FORCE_PAIR)
  ) u_classify (
    .value(i_value),
    .seq  (seq)
  );

  assign o_ready       = (state_reg == IDLE);
  assign o_instr_valid = (state_reg != IDLE);
  assign o_instr       = instr_reg;
  assign o_last        = last_reg;

  // Next-state and next-word selection; the second word of a pair is built at
  // accept time so later input changes cannot affect it.
  always_comb begin
    state_next  = state_reg;
    instr_next  = instr_reg;
    last_next   = last_reg;
    second_next = second_reg;
    unique case (state_reg)
      IDLE: begin
        if (i_valid && i_rt != 5'd0) begin
          state_next = EMIT1;
          last_next  = 1'b1;
          unique case (seq)
            SEQ_ORI:   instr_next = itype(OP_ORI, 5'd0, i_rt, lo);
            SEQ_ADDIU: instr_next = itype(OP_ADDIU, 5'd0, i_rt, lo);
            SEQ_LUI:   instr_next = itype(OP_LUI, 5'd0, i_rt, hi);
            SEQ_PAIR: begin
              instr_next  = itype(OP_LUI, 5'd0, i_rt, hi);
              last_next   = 1'b0;
              second_next = itype(OP_ORI, i_rt, i_rt, lo);
            end
            default:   instr_next = itype(OP_LUI, 5'd0, i_rt, hi);
          endcase
        end
      end
      EMIT1: begin
        if (i_instr_ready) begin
          if (!last_reg) begin
            state_next = EMIT2;
            instr_next = second_reg;
            last_next  = 1'b1;
          end else begin
            state_next = IDLE;
            last_next  = 1'b0;
          end
        end
      end
      EMIT2: begin
        if (i_instr_ready) begin
          state_next = IDLE;
          last_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        last_next  = 1'b0;
      end
    endcase
  end

  // State and output-word registers; reset discards any pending sequence.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg  <= IDLE;
      instr_reg  <= 32'h0;
      last_reg   <= 1'b0;
      second_reg <= 32'h0;
    end else begin
      state_reg  <= state_next;
      instr_reg  <= instr_next;
      last_reg   <= last_next;
      second_reg <= second_next;
    end
  end

`ifdef LI_EXPANDER_STATS_EN
  logic [31:0] word_cnt_reg;
  logic [31:0] pair_cnt_reg;

  // Free-running statistics; both wrap naturally at 2^32.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_cnt_reg <= 32'h0;
      pair_cnt_reg <= 32'h0;
    end else begin
      if (o_instr_valid && i_instr_ready) begin
        word_cnt_reg <= word_cnt_reg + 32'd1;
      end
      if (i_valid && o_ready && i_rt != 5'd0 && seq == SEQ_PAIR) begin
        pair_cnt_reg <= pair_cnt_reg + 32'd1;
      end
    end
  end

  assign o_word_cnt = word_cnt_reg;
  assign o_pair_cnt = pair_cnt_reg;
`endif

endmodule

// File: tb/tb_li_expander.sv
// tb_li_expander: two DUT instances (FORCE_PAIR=0 and FORCE_PAIR=1) checked
// against a value-reproduction reference model.
module tb_li_expander;

  logic        clk;
  logic        reset;
  logic [1:0]  valid;
  logic [1:0]  ready_o;
  logic [31:0] value_in [2];
  logic [4:0]  rt_in    [2];
  logic [1:0]  ivalid_o;
  logic [1:0]  iready;
  logic [31:0] instr_o  [2];
  logic [1:0]  last_o;

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  li_expander #(.FORCE_PAIR(0)) u_dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_valid      (valid[0]),
    .o_ready      (ready_o[0]),
    .i_value      (value_in[0]),
    .i_rt         (rt_in[0]),
    .o_instr_valid(ivalid_o[0]),
    .i_instr_ready(iready[0]),
    .o_instr      (instr_o[0]),
    .o_last       (last_o[0])
  );

  li_expander #(.FORCE_PAIR(1)) u_dut_fp (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_valid      (valid[1]),
    .o_ready      (ready_o[1]),
    .i_value      (value_in[1]),
    .i_rt         (rt_in[1]),
    .o_instr_valid(ivalid_o[1]),
    .i_instr_ready(iready[1]),
    .o_instr      (instr_o[1]),
    .o_last       (last_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: pick the shortest form whose architectural result equals the
  // requested constant (ORI zero-extends, ADDIU sign-extends, LUI fills upper).
  function automatic int expect_words(input logic [31:0] v, input logic [4:0] rt,
                                      input bit fp,
                                      output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] hi, lo, sext_lo, lui_w, ori_pair;
    hi = v >> 16;
    lo = v & 32'hFFFF;
    sext_lo = (lo >= 32'h8000) ? (lo | 32'hFFFF_0000) : lo;
    lui_w    = (32'h0F << 26) | (32'(rt) << 16) | hi;
    ori_pair = (32'h0D << 26) | (32'(rt) << 21) | (32'(rt) << 16) | lo;
    w0 = 32'h0;
    w1 = 32'h0;
    if (rt == 5'd0) return 0;
    if (!fp) begin
      if (v == lo) begin
        w0 = (32'h0D << 26) | (32'(rt) << 16) | lo;
        return 1;
      end
      if (v == sext_lo) begin
        w0 = (32'h09 << 26) | (32'(rt) << 16) | lo;
        return 1;
      end
      if (v == (hi << 16)) begin
        w0 = lui_w;
        return 1;
      end
    end
    w0 = lui_w;
    w1 = ori_pair;
    return 2;
  endfunction

  task automatic run_req(input int d, input logic [31:0] v, input logic [4:0] rt,
                         input int s0, input int s1);
    logic [31:0] w0, w1, exp;
    int n, stalls;
    bit explast;
    n = expect_words(v, rt, (d == 1), w0, w1);
    $display("req dut=%0d value=%h rt=%0d words=%0d w0=%h w1=%h", d, v, rt, n, w0, w1);
    check("idle_ready", 32'(ready_o[d]), 32'd1);
    valid[d] = 1'b1;
    value_in[d] = v;
    rt_in[d] = rt;
    @(posedge clk); #1;
    valid[d] = 1'b0;
    value_in[d] = $urandom;
    rt_in[d] = 5'($urandom);
    if (n == 0) begin
      check("rt0_no_valid", 32'(ivalid_o[d]), 32'd0);
      check("rt0_ready", 32'(ready_o[d]), 32'd1);
      return;
    end
    for (int k = 0; k < n; k++) begin
      exp = (k == 0) ? w0 : w1;
      explast = (k == n - 1);
      stalls = (k == 0) ? s0 : s1;
      for (int s = 0; s < stalls; s++) begin
        iready[d] = 1'b0;
        check("stall_valid", 32'(ivalid_o[d]), 32'd1);
        check("stall_instr", instr_o[d], exp);
        check("stall_last", 32'(last_o[d]), 32'(explast));
        check("stall_ready", 32'(ready_o[d]), 32'd0);
        @(posedge clk); #1;
      end
      iready[d] = 1'b1;
      check("word_valid", 32'(ivalid_o[d]), 32'd1);
      check("word_instr", instr_o[d], exp);
      check("word_last", 32'(last_o[d]), 32'(explast));
      check("word_ready", 32'(ready_o[d]), 32'd0);
      @(posedge clk); #1;
    end
    check("done_valid", 32'(ivalid_o[d]), 32'd0);
    check("done_ready", 32'(ready_o[d]), 32'd1);
  endtask

  function automatic logic [31:0] rand_value();
    logic [15:0] hi, lo;
    case ($urandom_range(0, 3))
      0: hi = 16'h0000;
      1: hi = 16'hFFFF;
      default: hi = 16'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: lo = 16'h0000;
      1: lo = 16'h8000 | 16'($urandom);
      2: lo = 16'h7FFF & 16'($urandom);
      default: lo = 16'($urandom);
    endcase
    return {hi, lo};
  endfunction

  initial begin
    reset = 1'b1;
    valid = 2'b00;
    iready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      value_in[d] = 32'h0;
      rt_in[d] = 5'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(ready_o[d]), 32'd1);
      check("rst_valid", 32'(ivalid_o[d]), 32'd0);
      check("rst_last", 32'(last_o[d]), 32'd0);
      check("rst_instr", instr_o[d], 32'h0);
    end

    // Directed cases
    run_req(0, 32'h0000_1234, 5'd8, 0, 0);
    run_req(0, 32'hFFFF_8000, 5'd9, 0, 0);
    run_req(0, 32'hFFFF_7FFF, 5'd9, 0, 0);
    run_req(0, 32'hABCD_0000, 5'd2, 0, 0);
    run_req(1, 32'hABCD_0000, 5'd2, 0, 0);
    run_req(0, 32'h1234_5678, 5'd4, 3, 0);
    run_req(0, 32'hDEAD_BEEF, 5'd0, 0, 0);
    run_req(0, 32'h0000_0000, 5'd31, 1, 0);
    run_req(1, 32'h0000_0000, 5'd0, 0, 0);

    // Reset while the ORI of a pair is pending
    run_req(0, 32'h0000_0001, 5'd1, 0, 0);
    valid[0] = 1'b1;
    value_in[0] = 32'h1234_5678;
    rt_in[0] = 5'd4;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    iready[0] = 1'b1;
    @(posedge clk); #1;
    check("emit2_instr", instr_o[0], 32'h3484_5678);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset in EMIT2 applied");
    check("rst2_valid", 32'(ivalid_o[0]), 32'd0);
    check("rst2_instr", instr_o[0], 32'h0);
    check("rst2_last", 32'(last_o[0]), 32'd0);
    check("rst2_ready", 32'(ready_o[0]), 32'd1);
    @(posedge clk); #1;
    check("rst2_no_ori", 32'(ivalid_o[0]), 32'd0);

    // Randomized traffic on both instances
    for (int i = 0; i < 60; i++) begin
      logic [4:0] rt;
      rt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_req(i % 2, rand_value(), rt, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
